// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - shares one Wishbone-style bus between the fetch and load/store ports
module mem_port_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 255,
    localparam int SEL_W  = DATA_W / 8
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              iport_req_i,
    input  logic [ADDR_W-1:0] iport_addr_i,
    input  logic              iport_flush_i,
    output logic [DATA_W-1:0] iport_data_o,
    output logic              iport_ack_o,
    output logic              iport_err_o,
    input  logic              dport_req_i,
    input  logic [ADDR_W-1:0] dport_addr_i,
    input  logic              dport_we_i,
    input  logic [SEL_W-1:0]  dport_sel_i,
    input  logic [DATA_W-1:0] dport_wdata_i,
    output logic [DATA_W-1:0] dport_rdata_o,
    output logic              dport_ack_o,
    output logic              dport_err_o,
    output logic              i_busy_o,
    output logic              d_busy_o,
    output logic [ADDR_W-1:0] wbm_addr_o,
    output logic [DATA_W-1:0] wbm_dat_o,
    output logic [SEL_W-1:0]  wbm_sel_o,
    output logic              wbm_we_o,
    output logic              wbm_cyc_o,
    output logic              wbm_stb_o,
    input  logic [DATA_W-1:0] wbm_dat_i,
    input  logic              wbm_ack_i,
    input  logic              wbm_err_i
);

    typedef enum logic [1:0] {IDLE, IBUS, DBUS, DONE} state_t;

    localparam logic [7:0] TMO_LAST = (TIMEOUT == 0) ? 8'd0 : 8'(TIMEOUT - 1);

    state_t            state;
    logic [7:0]        tmo_cnt;
    logic              discard;
    logic              timed_out;
    logic              bus_err;
    logic              bus_end;
    logic              drop_fetch;
    logic [DATA_W-1:0] resp_data;

    always_comb begin
        timed_out  = (TIMEOUT != 0) && (tmo_cnt == TMO_LAST);
        bus_err    = wbm_err_i | timed_out;
        bus_end    = wbm_ack_i | bus_err;
        resp_data  = bus_err ? '0 : wbm_dat_i;
        // a flush seen in the terminating cycle itself must still kill the response
        drop_fetch = discard | iport_flush_i;
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state         <= IDLE;
            tmo_cnt       <= 8'd0;
            discard       <= 1'b0;
            iport_data_o  <= '0;
            iport_ack_o   <= 1'b0;
            iport_err_o   <= 1'b0;
            dport_rdata_o <= '0;
            dport_ack_o   <= 1'b0;
            dport_err_o   <= 1'b0;
            wbm_addr_o    <= '0;
            wbm_dat_o     <= '0;
            wbm_sel_o     <= '0;
            wbm_we_o      <= 1'b0;
            wbm_cyc_o     <= 1'b0;
            wbm_stb_o     <= 1'b0;
        end else begin
            iport_ack_o   <= 1'b0;
            iport_err_o   <= 1'b0;
            iport_data_o  <= '0;
            dport_ack_o   <= 1'b0;
            dport_err_o   <= 1'b0;
            dport_rdata_o <= '0;
            case (state)
                IDLE: begin
                    tmo_cnt <= 8'd0;
                    if (dport_req_i) begin
                        wbm_addr_o <= dport_addr_i;
                        wbm_dat_o  <= dport_wdata_i;
                        wbm_sel_o  <= dport_sel_i;
                        wbm_we_o   <= dport_we_i;
                        wbm_cyc_o  <= 1'b1;
                        wbm_stb_o  <= 1'b1;
                        state      <= DBUS;
                    end else if (iport_req_i) begin
                        wbm_addr_o <= iport_addr_i;
                        wbm_sel_o  <= '1;
                        wbm_we_o   <= 1'b0;
                        wbm_cyc_o  <= 1'b1;
                        wbm_stb_o  <= 1'b1;
                        state      <= IBUS;
                    end
                end
                IBUS: begin
                    if (iport_flush_i) begin
                        discard <= 1'b1;
                    end
                    if (bus_end) begin
                        wbm_cyc_o <= 1'b0;
                        wbm_stb_o <= 1'b0;
                        state     <= DONE;
                        if (!drop_fetch) begin
                            iport_ack_o  <= ~bus_err;
                            iport_err_o  <= bus_err;
                            iport_data_o <= resp_data;
                        end
                    end else begin
                        tmo_cnt <= tmo_cnt + 8'd1;
                    end
                end
                DBUS: begin
                    if (bus_end) begin
                        wbm_cyc_o     <= 1'b0;
                        wbm_stb_o     <= 1'b0;
                        state         <= DONE;
                        dport_ack_o   <= ~bus_err;
                        dport_err_o   <= bus_err;
                        dport_rdata_o <= resp_data;
                    end else begin
                        tmo_cnt <= tmo_cnt + 8'd1;
                    end
                end
                default: begin
                    // response pulse is visible during this cycle; bus is free again next
                    state   <= IDLE;
                    tmo_cnt <= 8'd0;
                    discard <= 1'b0;
                end
            endcase
        end
    end

    assign i_busy_o = iport_req_i & ~iport_ack_o & ~iport_err_o;
    assign d_busy_o = dport_req_i & ~dport_ack_o & ~dport_err_o;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - scoreboard bench for mem_port_arbiter
module tb_mem_port_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        ireq, iflush, iack, ierr, ibusy;
    logic [31:0] iaddr, idata;
    logic        dreq, dwe, dack, derr, dbusy;
    logic [31:0] daddr, dwdata, drdata;
    logic [3:0]  dsel;
    logic [31:0] m_addr, m_dat, s_dat;
    logic [3:0]  m_sel;
    logic        m_we, m_cyc, m_stb, s_ack, s_err;

    logic        t_dreq, t_iack, t_ierr, t_dack, t_derr, t_ibusy, t_dbusy;
    logic [31:0] t_idata, t_drdata, t_addr, t_dat;
    logic [3:0]  t_sel;
    logic        t_we, t_cyc, t_stb;

    int checks = 0;
    int fails  = 0;

    mem_port_arbiter dut (
        .clk_i(clk), .rst_n_i(rst_n),
        .iport_req_i(ireq), .iport_addr_i(iaddr), .iport_flush_i(iflush),
        .iport_data_o(idata), .iport_ack_o(iack), .iport_err_o(ierr),
        .dport_req_i(dreq), .dport_addr_i(daddr), .dport_we_i(dwe), .dport_sel_i(dsel),
        .dport_wdata_i(dwdata), .dport_rdata_o(drdata), .dport_ack_o(dack), .dport_err_o(derr),
        .i_busy_o(ibusy), .d_busy_o(dbusy),
        .wbm_addr_o(m_addr), .wbm_dat_o(m_dat), .wbm_sel_o(m_sel), .wbm_we_o(m_we),
        .wbm_cyc_o(m_cyc), .wbm_stb_o(m_stb),
        .wbm_dat_i(s_dat), .wbm_ack_i(s_ack), .wbm_err_i(s_err)
    );

    mem_port_arbiter #(.TIMEOUT(4)) dut_to (
        .clk_i(clk), .rst_n_i(rst_n),
        .iport_req_i(1'b0), .iport_addr_i(32'h0), .iport_flush_i(1'b0),
        .iport_data_o(t_idata), .iport_ack_o(t_iack), .iport_err_o(t_ierr),
        .dport_req_i(t_dreq), .dport_addr_i(32'h40), .dport_we_i(1'b0), .dport_sel_i(4'hf),
        .dport_wdata_i(32'h0), .dport_rdata_o(t_drdata), .dport_ack_o(t_dack), .dport_err_o(t_derr),
        .i_busy_o(t_ibusy), .d_busy_o(t_dbusy),
        .wbm_addr_o(t_addr), .wbm_dat_o(t_dat), .wbm_sel_o(t_sel), .wbm_we_o(t_we),
        .wbm_cyc_o(t_cyc), .wbm_stb_o(t_stb),
        .wbm_dat_i(32'hFFFF_FFFF), .wbm_ack_i(1'b0), .wbm_err_i(1'b0)
    );

    // Slave: terminates after slave_wait extra cycles; mode 0 ack, 1 err, 2 both, 3 never
    int          slave_wait = 0;
    int          slave_mode = 0;
    logic [31:0] slave_rdata = 32'h0;
    int          scnt = 0;
    logic        hit;
    always @(posedge clk) begin
        if (m_cyc && m_stb && !(s_ack || s_err)) scnt <= scnt + 1;
        else scnt <= 0;
    end
    assign hit   = m_cyc && m_stb && (scnt == slave_wait);
    assign s_ack = hit && (slave_mode == 0 || slave_mode == 2);
    assign s_err = hit && (slave_mode == 1 || slave_mode == 2);
    assign s_dat = slave_rdata;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    typedef struct {bit dport; bit err; logic [31:0] data;} resp_t;
    typedef struct {logic [31:0] addr; bit we; logic [3:0] sel; logic [31:0] wdat; int cycles;} bus_t;
    resp_t rq[$];
    bus_t  bq[$];

    task automatic pop_resp(input bit port, input bit err, input logic [31:0] data);
        resp_t e;
        if (rq.size() == 0) begin
            checks++;
            fails++;
            $display("FAIL unexpected_resp: got port=%0d err=%0d data=%0h expected none", port, err, data);
        end else begin
            e = rq.pop_front();
            check("resp_port", 64'(port), 64'(e.dport));
            check("resp_err", 64'(err), 64'(e.err));
            check("resp_data", 64'(data), 64'(e.data));
        end
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            if (iack || ierr) pop_resp(1'b0, ierr, idata);
            if (dack || derr) pop_resp(1'b1, derr, drdata);
        end
    end

    logic        prev_cyc = 1'b0;
    int          bcnt = 0;
    logic [31:0] c_addr, c_dat;
    logic [3:0]  c_sel;
    logic        c_we;
    always @(negedge clk) begin
        bus_t e;
        if (m_cyc === 1'b1) begin
            check("stb_eq_cyc", 64'(m_stb), 64'd1);
            if (!prev_cyc) begin
                c_addr = m_addr; c_dat = m_dat; c_sel = m_sel; c_we = m_we;
                bcnt = 1;
            end else begin
                bcnt++;
                check("bus_frozen", {m_addr, m_sel, m_we}, {c_addr, c_sel, c_we});
            end
        end else if (prev_cyc) begin
            if (bq.size() == 0) begin
                checks++;
                fails++;
                $display("FAIL unexpected_bus: got addr=%0h expected none", c_addr);
            end else begin
                e = bq.pop_front();
                check("bus_addr", 64'(c_addr), 64'(e.addr));
                check("bus_we", 64'(c_we), 64'(e.we));
                check("bus_sel", 64'(c_sel), 64'(e.sel));
                if (e.we) check("bus_wdat", 64'(c_dat), 64'(e.wdat));
                if (e.cycles >= 0) check("bus_cycles", 64'(bcnt), 64'(e.cycles));
            end
        end
        prev_cyc = (m_cyc === 1'b1);
    end

    task automatic dport_txn(input logic [31:0] a, input logic we, input logic [3:0] sel,
                             input logic [31:0] wd);
        bit got = 0;
        dreq = 1'b1; daddr = a; dwe = we; dsel = sel; dwdata = wd;
        for (int i = 0; i < 60 && !got; i++) begin
            @(negedge clk);
            got = dack || derr;
        end
        if (!got) begin
            checks++; fails++;
            $display("FAIL dport_timeout: got no response expected ack/err");
        end
        @(posedge clk); #1;
        dreq = 1'b0;
    endtask

    task automatic iport_txn(input logic [31:0] a);
        bit got = 0;
        ireq = 1'b1; iaddr = a;
        for (int i = 0; i < 60 && !got; i++) begin
            @(negedge clk);
            got = iack || ierr;
        end
        if (!got) begin
            checks++; fails++;
            $display("FAIL iport_timeout: got no response expected ack/err");
        end
        @(posedge clk); #1;
        ireq = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n_ack;
        int cyc_n;
        bit seen;
        rst_n = 1'b0; ireq = 0; iaddr = 0; iflush = 0;
        dreq = 0; daddr = 0; dwe = 0; dsel = 0; dwdata = 0; t_dreq = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_bus", {m_cyc, m_stb, m_we, m_addr, m_sel}, 64'd0);
        check("reset_resp", {iack, ierr, dack, derr, idata}, 64'd0);
        check("reset_drdata", 64'(drdata), 64'd0);
        check("reset_to_bus", {t_cyc, t_stb, t_dack, t_derr}, 64'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (2) @(posedge clk);

        // zero-wait fetch
        #1;
        slave_wait = 0; slave_mode = 0; slave_rdata = 32'h13;
        rq.push_back('{1'b0, 1'b0, 32'h13});
        bq.push_back('{32'h100, 1'b0, 4'hf, 32'h0, 1});
        ireq = 1'b1; iaddr = 32'h100;
        @(negedge clk);
        check("c1_ibusy", 64'(ibusy), 64'd1);
        check("c1_cyc", 64'(m_cyc), 64'd0);
        @(negedge clk);
        check("c2_cyc", 64'(m_cyc), 64'd1);
        check("c2_ibusy", 64'(ibusy), 64'd1);
        @(negedge clk);
        check("c3_iack", 64'(iack), 64'd1);
        check("c3_ibusy", 64'(ibusy), 64'd0);
        @(posedge clk); #1;
        ireq = 1'b0;
        repeat (3) @(posedge clk);

        // simultaneous store and fetch: store wins
        #1;
        slave_rdata = 32'h55AA;
        rq.push_back('{1'b1, 1'b0, 32'h55AA});
        rq.push_back('{1'b0, 1'b0, 32'h55AA});
        bq.push_back('{32'h2000, 1'b1, 4'hf, 32'hDEADBEEF, 1});
        bq.push_back('{32'h104, 1'b0, 4'hf, 32'h0, 1});
        fork
            dport_txn(32'h2000, 1'b1, 4'hf, 32'hDEADBEEF);
            iport_txn(32'h104);
        join
        repeat (3) @(posedge clk);

        // load with wait states: ack in the 5th strobe cycle
        #1;
        slave_wait = 4; slave_rdata = 32'hCAFEF00D;
        rq.push_back('{1'b1, 1'b0, 32'hCAFEF00D});
        bq.push_back('{32'h3000, 1'b0, 4'h3, 32'h0, 5});
        dreq = 1'b1; daddr = 32'h3000; dwe = 1'b0; dsel = 4'h3;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("wait_dbusy", 64'(dbusy), 64'd1);
        end
        @(negedge clk);
        check("wait_dack", 64'(dack), 64'd1);
        check("wait_dbusy_at_ack", 64'(dbusy), 64'd0);
        @(posedge clk); #1;
        dreq = 1'b0;
        @(negedge clk);
        check("wait_ack_one_cycle", {dack, drdata}, 64'd0);
        repeat (3) @(posedge clk);

        // flush in the 2nd cycle of a 3-wait fetch, then refetch at 0x200
        #1;
        slave_wait = 3; slave_rdata = 32'h22;
        bq.push_back('{32'h300, 1'b0, 4'hf, 32'h0, 4});
        bq.push_back('{32'h200, 1'b0, 4'hf, 32'h0, 4});
        rq.push_back('{1'b0, 1'b0, 32'h22});
        ireq = 1'b1; iaddr = 32'h300;
        n_ack = 0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        iflush = 1'b1; iaddr = 32'h200;
        @(posedge clk); #1;
        iflush = 1'b0;
        seen = 0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            if (iack) n_ack++;
            seen = iack && (m_addr == 32'h200);
        end
        check("flush_ack_count", 64'(n_ack), 64'd1);
        @(posedge clk); #1;
        ireq = 1'b0;
        repeat (3) @(posedge clk);

        // bus err with simultaneous ack, then plain err on fetch
        #1;
        slave_wait = 0; slave_mode = 2; slave_rdata = 32'h77;
        rq.push_back('{1'b1, 1'b1, 32'h0});
        bq.push_back('{32'h4000, 1'b0, 4'hf, 32'h0, 1});
        dport_txn(32'h4000, 1'b0, 4'hf, 32'h0);
        slave_mode = 1;
        rq.push_back('{1'b0, 1'b1, 32'h0});
        bq.push_back('{32'h108, 1'b0, 4'hf, 32'h0, 1});
        iport_txn(32'h108);
        repeat (3) @(posedge clk);

        // timeout with TIMEOUT=4 and a silent slave
        #1;
        t_dreq = 1'b1;
        cyc_n = 0; seen = 0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            if (t_cyc) cyc_n++;
            seen = t_derr;
        end
        check("to_cycles", 64'(cyc_n), 64'd4);
        check("to_err_seen", 64'(seen), 64'd1);
        check("to_no_ack", {t_dack, t_drdata}, 64'd0);
        @(posedge clk); #1;
        t_dreq = 1'b0;
        @(negedge clk);
        check("to_err_one_cycle", 64'(t_derr), 64'd0);
        repeat (2) @(posedge clk);

        // reset in the middle of a long store
        #1;
        slave_mode = 0; slave_wait = 20;
        bq.push_back('{32'h5000, 1'b1, 4'hf, 32'h12345678, -1});
        dreq = 1'b1; daddr = 32'h5000; dwe = 1'b1; dsel = 4'hf; dwdata = 32'h12345678;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b0; dreq = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_mid_bus", {m_cyc, m_stb, dack, derr, iack, ierr}, 64'd0);
        n_ack = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (dack || derr || m_cyc) n_ack++;
        end
        check("rst_mid_quiet", 64'(n_ack), 64'd0);

        check("rq_empty", 64'(rq.size()), 64'd0);
        check("bq_empty", 64'(bq.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the core's single Wishbone-style memory bus between the instruction-fetch port (IF stage) and the load/store data port (MEM stage).
- Sequences one bus transaction at a time and returns one-cycle ack/err pulses to the winning port.
- Generates the hazard-unit busy flags d_busy_o (drives is_MEM) and i_busy_o (drives is_IF).
- Discards stale fetch responses after a pipeline flush and terminates hung transactions with a bus timeout.

Parameters:
- ADDR_W, 32, address width of both ports and the bus.
- DATA_W, 32, data width; SEL_W = DATA_W/8.
- TIMEOUT, 255, maximum bus cycles to wait for ack/err before forcing an error; 0 disables the timeout; the counter is 8 bits.

Ports:
- clk_i  in  1  core clock; all logic rises on its posedge.
- rst_n_i  in  1  synchronous active-low reset.
- iport_req_i  in  1  fetch request; held with stable address until iport_ack_o or iport_err_o.
- iport_addr_i  in  ADDR_W  fetch address.
- iport_flush_i  in  1  IF/ID flush (branch, jump, trap, mret); current fetch response must be dropped.
- iport_data_o  out  DATA_W  fetched word; valid while iport_ack_o.
- iport_ack_o  out  1  one-cycle fetch completion.
- iport_err_o  out  1  one-cycle fetch bus error or timeout.
- dport_req_i  in  1  load/store request; held with stable fields until dport ack or err.
- dport_addr_i  in  ADDR_W  data address.
- dport_we_i  in  1  1 = store.
- dport_sel_i  in  SEL_W  byte lanes.
- dport_wdata_i  in  DATA_W  store data.
- dport_rdata_o  out  DATA_W  load data; valid while dport_ack_o.
- dport_ack_o  out  1  one-cycle data completion.
- dport_err_o  out  1  one-cycle data error or timeout.
- i_busy_o  out  1  fetch outstanding, to hazard unit is_IF.
- d_busy_o  out  1  load/store outstanding, to hazard unit is_MEM.
- wbm_addr_o  out  ADDR_W  bus address.
- wbm_dat_o  out  DATA_W  bus write data.
- wbm_sel_o  out  SEL_W  bus byte select.
- wbm_we_o  out  1  bus write enable.
- wbm_cyc_o  out  1  bus cycle.
- wbm_stb_o  out  1  bus strobe.
- wbm_dat_i  in  DATA_W  bus read data.
- wbm_ack_i  in  1  bus ack.
- wbm_err_i  in  1  bus error.

Behaviour:
- Reset (rst_n_i=0 at posedge):
  - state=IDLE; every registered output is 0 (all wbm_* outputs, iport/dport ack, err and data outputs).
  - Timeout counter=0; discard flag=0; any transaction in flight is abandoned with no ack.
- FSM states: IDLE, IBUS, DBUS, DONE.
- IDLE:
  - If dport_req_i: latch dport fields onto wbm_*, set cyc=stb=1, go to DBUS.
  - Else if iport_req_i: latch iport_addr_i, we=0, sel=all ones, cyc=stb=1, go to IBUS.
  - Data port has fixed priority over fetch.
  - No starvation: a port drops req for at least one cycle after its ack.
- IBUS/DBUS:
  - cyc/stb stay high and bus fields stay frozen.
  - Counter increments each cycle.
  - On wbm_ack_i or wbm_err_i sampled high: capture wbm_dat_i (0 on err), drop cyc/stb, go to DONE.
  - If TIMEOUT!=0 and counter==TIMEOUT-1 with no ack/err: treat as err.
  - If ack and err are both high, err wins.
- DONE (exactly one cycle):
  - Pulse the owning port's ack_o (or err_o) with its data output; then go to IDLE and clear the counter.
  - Data outputs return to 0 when ack is low.
- Latency: request seen in cycle N → cyc/stb in N+1 → zero-wait slave acks in N+1 → port ack in N+2.
  - Next grant is evaluated in N+3.
  - Back-to-back throughput is therefore one transaction per 3 cycles.
- Flush:
  - iport_flush_i high in any IBUS cycle, including the ack cycle, sets the discard flag.
  - The bus transaction still completes normally; no abort mid-cycle.
  - In DONE with discard=1, iport_ack_o and iport_err_o stay 0 and data stays 0; the flag clears.
  - Flush in IDLE or DBUS has no effect.
  - Flush during the DONE cycle does not retract the ack; the core ignores it.
- Busy flags (combinational):
  - i_busy_o = iport_req_i & ~iport_ack_o & ~iport_err_o.
  - d_busy_o = dport_req_i & ~dport_ack_o & ~dport_err_o.
  - Both may be high together; the hazard unit prioritises is_MEM.
- Requester protocol violations (req dropped before ack): the transaction completes and the response pulse is still issued. The bench does not check for this.

Test Plan:
- Fetch only, zero-wait slave: iport_req at cycle 1, addr 0x100, slave data 0x00000013 → cyc/stb cycles 2; iport_ack_o=1 with data 0x13 in cycle 3; i_busy_o high cycles 1–2.
- Simultaneous: iport_req and dport_req store (addr 0x2000, wdata 0xDEADBEEF, sel 4'b1111) in the same cycle → store granted first with wbm_we_o=1; dport_ack_o pulses; fetch is granted in the cycle after IDLE sees dport_req low.
- Wait states: slave acks 5 cycles after stb on a load → cyc/stb high 5 cycles with frozen fields; dport_rdata_o valid exactly 1 cycle; d_busy_o high throughout.
- Flush: iport_flush_i pulsed in the 2nd cycle of a 3-wait fetch → bus completes, iport_ack_o never asserts; a new fetch at 0x200 is then served normally.
- Timeout: TIMEOUT=4, slave never acks → cyc/stb high exactly 4 cycles, then dport_err_o pulses one cycle; bus err with simultaneous ack → err_o only.
- Reset mid-transaction: rst_n_i low during DBUS → next cycle cyc/stb/acks all 0, state IDLE, no ack or err issued afterwards.
